// File: rtl/led7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: a blank/show FSM walks the
// digits, decoding one hex register at a time onto shared active-low segments.
module led7_scan_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic       i_w_wr_en,
  input  logic [1:0] i_w_wr_addr,
  input  logic [3:0] i_w_wr_data,
  input  logic       i_w_blank,
  output logic [6:0] o_w_seg,
  output logic [3:0] o_w_an,
  output logic [1:0] o_w_digit,
  output logic       o_w_frame
);

  typedef enum logic {S_BLANK, S_SHOW} state_t;

  localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [1:0]  idx_reg, idx_next;
  logic        frame_reg, frame_next;
  logic        blank_reg;
  logic [3:0]  digit_reg [4];
  logic        show;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_reg <= S_BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      frame_reg <= 1'b0;
      blank_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      frame_reg <= frame_next;
      blank_reg <= i_w_blank;
    end
  end

  // Digit registers are independent of scan timing; a write lands at the edge.
  always_ff @(posedge i_w_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_w_reset) begin
        digit_reg[i] <= '0;
      end else if (i_w_wr_en && (i_w_wr_addr == 2'(i))) begin
        digit_reg[i] <= i_w_wr_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    frame_next = 1'b0;
    case (state_reg)
      S_BLANK: begin
        state_next = S_SHOW;
        cnt_next   = '0;
      end
      S_SHOW: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = S_BLANK;
          cnt_next   = '0;
          idx_next   = idx_reg + 2'd1;
          // Frame marks the blank slot that follows the wrap from digit 3.
          frame_next = (idx_reg == 2'd3);
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        state_next = S_BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  assign show      = (state_reg == S_SHOW) && !blank_reg;
  assign o_w_seg   = show ? hex_decode(digit_reg[idx_reg]) : 7'b1111111;
  assign o_w_an    = show ? ~(4'b0001 << idx_reg) : 4'b1111;
  assign o_w_digit = idx_reg;
  assign o_w_frame = frame_reg;

endmodule
